// File: rtl/param_bit_counter.sv
// Multi-mode bit counter: popcount of ones/zeros, leading or trailing zeros of a WIDTH-bit operand.
// Controller/datapath in one always_ff; start/done level handshake, one bit examined per clock.
module param_bit_counter #(
  parameter int WIDTH = 8,
  parameter int RW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [RW-1:0]    result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [RW-1:0] FULL = RW'(WIDTH);
  localparam logic [RW-1:0] ONE  = RW'(1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [1:0]       mode_q;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state  <= S_IDLE;
      sreg   <= '0;
      mode_q <= 2'b00;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // zero-popcount reuses the ones datapath on the inverted operand
            sreg   <= (mode == 2'b01) ? ~data_in : data_in;
            mode_q <= mode;
            result <= '0;
            state  <= S_RUN;
            busy   <= 1'b1;
          end
        end
        S_RUN: begin
          case (mode_q)
            2'b00, 2'b01: begin
              if (sreg == '0) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                result <= result + {{(RW-1){1'b0}}, sreg[0]};
                sreg   <= sreg >> 1;
              end
            end
            2'b11: begin
              if (sreg == '0) begin
                result <= FULL;
                state  <= S_DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else if (sreg[0]) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                result <= result + ONE;
                sreg   <= sreg >> 1;
              end
            end
            default: begin
              if (sreg == '0) begin
                result <= FULL;
                state  <= S_DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else if (sreg[WIDTH-1]) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                result <= result + ONE;
                sreg   <= sreg << 1;
              end
            end
          endcase
        end
        S_DONE: begin
          if (!start) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/param_bit_counter.md
Name: param_bit_counter

Overview:
- Parametrised, multi-mode successor to the lab's 8-bit ASMD ones-counter.
- Handles any operand width and counts one of four quantities: set bits, clear bits, leading zeros or trailing zeros.
- Uses a controller/datapath split with the same start/done level handshake (start held high, done held until start drops).
- Feeds the seg7 display path and status LEDs at top level.

Parameters:
- WIDTH, 8: operand width in bits; must be 2 or more.
- RW, $clog2(WIDTH+1): result width, wide enough to hold the value WIDTH.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- start  in  1  level request; sampled only in IDLE and DONE.
- data_in  in  WIDTH  operand; captured on the start-sampling edge only.
- mode  in  2  operation select, captured with data_in:
  - 00: popcount of ones
  - 01: popcount of zeros
  - 10: count leading zeros (from the MSB)
  - 11: count trailing zeros (from the LSB)
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE; result is valid.
- result  out  RW  count; stable whenever done is high.

Behaviour:
- Reset (reset_b low, asynchronous):
  - State goes to IDLE; busy=0, done=0, result=0.
  - The internal shift register and captured mode are cleared.
  - Reset mid-RUN aborts the operation; no done is produced.
- IDLE:
  - If start=1 at an edge ("E0"):
    - sreg <= data_in, or ~data_in when mode=01.
    - mode_q <= mode; result <= 0; go to RUN.
  - If start=0, stay in IDLE.
- RUN: one decision per edge, evaluated on the current sreg.
  - Popcount (mode_q 0x):
    - If sreg==0, go to DONE with no update.
    - Otherwise, result += sreg[0] and sreg >>= 1 (zero fill).
  - Trailing zeros (11):
    - If sreg==0: result <= WIDTH, go to DONE.
    - Else if sreg[0]==1: go to DONE.
    - Else: result += 1, sreg >>= 1.
  - Leading zeros (10): same rules using sreg[WIDTH-1] and sreg <<= 1.
  - start, data_in and mode are ignored throughout RUN.
- Latency (edges from E0 to done rising):
  - Popcount: h+1, where h = 1 + index of the highest set bit of the loaded sreg (h=0 when sreg is all zeros).
  - Trailing zeros: t+1, where t is the number of trailing zeros. All-zero operand gives 1 edge.
  - Leading zeros: l+1, where l is the number of leading zeros. All-zero operand gives 1 edge.
  - Worst case is WIDTH+1 edges.
- DONE:
  - done=1 and result is held.
  - Stay in DONE while start=1; go to IDLE at the first edge with start=0.
  - result remains valid in IDLE until the next E0 clears it.
  - The earliest new operation starts 2 edges after done rises, and only if start drops and rises again.
- Arithmetic:
  - result increments are unsigned RW-bit and can never exceed WIDTH.
  - The all-zero case loads WIDTH directly.
- busy and done are registered state decodes; they are never both high.
- A start glitch while in DONE has no effect as long as start stays high.

Test Plan:
- WIDTH=8, mode=00, data_in=0x00, start held high -> done rises 1 edge after E0, result=0; drop start -> IDLE next edge, result still 0.
- WIDTH=8, mode=00, data_in=0xFF -> done after 9 edges, result=8. Then data_in=0xAA -> done after 9 edges, result=4. Then data_in=0x01 -> done after 2 edges, result=1.
- WIDTH=8, mode=01, data_in=0xAA (loaded as 0x55) -> done after 8 edges, result=4. Then data_in=0xFF -> done after 1 edge, result=0.
- WIDTH=8, mode=11, data_in=0x28 -> done after 4 edges, result=3. Then data_in=0x00 -> done after 1 edge, result=8.
- WIDTH=8, mode=10, data_in=0x28 -> done after 3 edges, result=2. Changing data_in and mode during RUN does not alter the result.
- WIDTH=12, mode=00, data_in=0xFFF with reset_b pulsed low at the 5th RUN edge -> immediate busy=0, done=0, result=0. A new start then gives done after 13 edges, result=12 (RW=4).
